// File: rtl/mriscv_pkg.sv
// mriscv_pkg: shared widths, funct3 codes and execute-stage state encoding
package mriscv_pkg;
  localparam int XLEN = 32;
  localparam int SHAMT_W = 5;
  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [0:0] ST_IDLE = 1'b0, ST_SHIFT = 1'b1;
endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: one-bit-per-cycle shifter; value is the operand after the current cycle's step
module serial_shifter
  import mriscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    value
);
  logic [XLEN-1:0] sh;
  logic [SHAMT_W-1:0] cnt;
  logic dir_q, arith_q;
  assign busy = cnt != '0;
  assign done = cnt == SHAMT_W'(1);
  assign value = dir_q ? {arith_q & sh[XLEN-1], sh[XLEN-1:1]} : {sh[XLEN-2:0], 1'b0};
  always_ff @(posedge clk)
    if (reset) begin
      sh <= '0;
      cnt <= '0;
      dir_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      sh <= operand;
      cnt <= shamt;
      dir_q <= dir;
      arith_q <= arith;
    end else if (busy) begin
      sh <= value;
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: ALU/branch/jump execute stage; MRISCV_FAST_SHIFT_EN selects a barrel shifter over the serial one
module exec_stage
  import mriscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            is_alu,
  input  logic            is_rtype,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_reg,
  input  logic            is_ui,
  input  logic            add_pc,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [XLEN-1:0] branch_dest,
  input  logic [4:0]      dest,
  input  logic [2:0]      func3,
  input  logic            func7,
  output logic            stall,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] result,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_target
);
  logic start, taken, go_shift, sh_busy, sh_done;
  logic [0:0] state;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0] alu_res, sh_value, link, jalr_sum;
  assign start = state == ST_IDLE && (is_alu || is_branch || is_jump || is_ui);
  assign shamt = operand_b[SHAMT_W-1:0];
  assign link = pc + XLEN'(4);
  assign jalr_sum = operand_a + operand_b;
  assign stall = state == ST_SHIFT;
  always_comb begin
    alu_res = operand_a;
    case (func3)
      F3_ADD:  alu_res = (is_rtype && func7) ? operand_a - operand_b : operand_a + operand_b;
      F3_SLT:  alu_res = XLEN'($signed(operand_a) < $signed(operand_b));
      F3_SLTU: alu_res = XLEN'(operand_a < operand_b);
      F3_XOR:  alu_res = operand_a ^ operand_b;
      F3_OR:   alu_res = operand_a | operand_b;
      F3_AND:  alu_res = operand_a & operand_b;
`ifdef MRISCV_FAST_SHIFT_EN
      F3_SLL:  alu_res = operand_a << shamt;
      F3_SR:   alu_res = func7 ? $unsigned($signed(operand_a) >>> shamt) : operand_a >> shamt;
`endif
      default: alu_res = operand_a;
    endcase
  end
  always_comb begin
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = operand_a == operand_b;
      F3_BNE:  taken = operand_a != operand_b;
      F3_BLT:  taken = $signed(operand_a) < $signed(operand_b);
      F3_BGE:  taken = $signed(operand_a) >= $signed(operand_b);
      F3_BLTU: taken = operand_a < operand_b;
      F3_BGEU: taken = operand_a >= operand_b;
      default: taken = 1'b0;
    endcase
  end
`ifdef MRISCV_FAST_SHIFT_EN
  assign go_shift = 1'b0;
  assign sh_busy = 1'b0;
  assign sh_done = 1'b0;
  assign sh_value = '0;
`else
  // Zero-length shifts take the single-cycle path with result = operand_a.
  assign go_shift = start && !is_jump && !is_branch && !is_ui &&
                    (func3 == F3_SLL || func3 == F3_SR) && shamt != '0;
  serial_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (go_shift),
    .operand (operand_a),
    .shamt   (shamt),
    .dir     (func3 == F3_SR),
    .arith   (func7),
    .busy    (sh_busy),
    .done    (sh_done),
    .value   (sh_value)
  );
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      wb_en <= 1'b0;
      pc_load <= 1'b0;
      wb_addr <= '0;
      result <= '0;
      pc_target <= '0;
    end else if (state == ST_SHIFT) begin
      if (sh_done || !sh_busy) begin
        state <= ST_IDLE;
        result <= sh_value;
        wb_en <= wb_addr != '0;
      end
    end else begin
      wb_en <= 1'b0;
      pc_load <= 1'b0;
      if (start) begin
        wb_addr <= dest;
        if (is_jump) begin
          pc_load <= 1'b1;
          pc_target <= is_reg ? {jalr_sum[XLEN-1:1], 1'b0} : pc + operand_a;
          result <= link;
          wb_en <= dest != '0;
        end else if (is_branch) begin
          pc_load <= taken;
          if (taken) pc_target <= pc + branch_dest;
        end else if (is_ui) begin
          result <= add_pc ? pc + operand_a : operand_a;
          wb_en <= dest != '0;
        end else if (go_shift) begin
          state <= ST_SHIFT;
        end else begin
          result <= alu_res;
          wb_en <= dest != '0;
        end
      end
    end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: randomized and directed checks of exec_stage against a behavioural model
module tb_exec_stage;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] pc, operand_a, operand_b, branch_dest;
  logic is_alu, is_rtype, is_branch, is_jump, is_reg, is_ui, add_pc;
  logic [4:0] dest;
  logic [2:0] func3;
  logic func7;
  logic stall, wb_en, pc_load;
  logic [4:0] wb_addr;
  logic [31:0] result, pc_target;
  int total = 0;
  int bad = 0;
  logic [31:0] m_res, m_tgt;
  logic [4:0] m_addr;
  logic m_wb, m_pcl;
  int m_lat;
  localparam logic [6:0] ALU = 7'b1000000, RT = 7'b0100000, BR = 7'b0010000, JP = 7'b0001000;
  localparam logic [6:0] RG = 7'b0000100, UI = 7'b0000010, AP = 7'b0000001;

  exec_stage dut (
    .clk(clk), .reset(reset), .pc(pc), .is_alu(is_alu), .is_rtype(is_rtype),
    .is_branch(is_branch), .is_jump(is_jump), .is_reg(is_reg), .is_ui(is_ui),
    .add_pc(add_pc), .operand_a(operand_a), .operand_b(operand_b),
    .branch_dest(branch_dest), .dest(dest), .func3(func3), .func7(func7),
    .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .result(result),
    .pc_load(pc_load), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] f, input logic [31:0] p, a, b, bd,
                       input logic [4:0] d, input logic [2:0] f3, input logic f7);
    {is_alu, is_rtype, is_branch, is_jump, is_reg, is_ui, add_pc} = f;
    pc = p; operand_a = a; operand_b = b; branch_dest = bd;
    dest = d; func3 = f3; func7 = f7;
  endtask

  task automatic clear_flags();
    {is_alu, is_branch, is_jump, is_ui} = '0;
  endtask

  // Architectural meaning of the current inputs; result/target hold when not written.
  task automatic model();
    int sh;
    logic t;
    m_wb = 0; m_pcl = 0; m_lat = 1;
    m_addr = dest;
    sh = int'(operand_b % 32);
    if (is_jump) begin
      m_pcl = 1;
      m_tgt = is_reg ? ((operand_a + operand_b) & 32'hFFFF_FFFE) : pc + operand_a;
      m_res = pc + 4;
      m_wb = dest != 0;
    end else if (is_branch) begin
      case (func3)
        3'd0: t = operand_a == operand_b;
        3'd1: t = operand_a != operand_b;
        3'd4: t = int'(operand_a) < int'(operand_b);
        3'd5: t = int'(operand_a) >= int'(operand_b);
        3'd6: t = operand_a < operand_b;
        3'd7: t = operand_a >= operand_b;
        default: t = 0;
      endcase
      m_pcl = t;
      if (t) m_tgt = pc + branch_dest;
    end else if (is_ui) begin
      m_res = add_pc ? pc + operand_a : operand_a;
      m_wb = dest != 0;
    end else begin
      case (func3)
        3'd0: m_res = (is_rtype && func7) ? operand_a - operand_b : operand_a + operand_b;
        3'd1: m_res = operand_a << sh;
        3'd2: m_res = (int'(operand_a) < int'(operand_b)) ? 1 : 0;
        3'd3: m_res = (operand_a < operand_b) ? 1 : 0;
        3'd4: m_res = operand_a ^ operand_b;
        3'd5: m_res = func7 ? 32'(int'(operand_a) >>> sh) : operand_a >> sh;
        3'd6: m_res = operand_a | operand_b;
        default: m_res = operand_a & operand_b;
      endcase
`ifndef MRISCV_FAST_SHIFT_EN
      if ((func3 == 3'd1 || func3 == 3'd5) && sh != 0) m_lat = sh + 1;
`endif
      m_wb = dest != 0;
    end
  endtask

  // Issues the op on the inputs, scrambles flags while stalled, then checks the completion cycle.
  task automatic run_op(input string name);
    model();
    @(posedge clk); #1;
    for (int c = 1; c < m_lat; c++) begin
      total++;
      if (stall !== 1'b1 || wb_en !== 1'b0 || pc_load !== 1'b0) begin
        bad++;
        $display("FAIL %s busy cycle %0d: stall=%b wb_en=%b pc_load=%b, required 1/0/0", name, c, stall, wb_en, pc_load);
      end
      {is_alu, is_rtype, is_branch, is_jump, is_reg, is_ui, add_pc} = 7'($urandom);
      operand_a = $urandom; operand_b = $urandom; dest = 5'($urandom); func3 = 3'($urandom);
      @(posedge clk); #1;
    end
    clear_flags();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL %s stall: got %b required 0", name, stall); end
    total++;
    if (wb_en !== m_wb) begin bad++; $display("FAIL %s wb_en: got %b required %b", name, wb_en, m_wb); end
    total++;
    if (pc_load !== m_pcl) begin bad++; $display("FAIL %s pc_load: got %b required %b", name, pc_load, m_pcl); end
    total++;
    if (wb_addr !== m_addr) begin bad++; $display("FAIL %s wb_addr: got %0d required %0d", name, wb_addr, m_addr); end
    total++;
    if (result !== m_res) begin bad++; $display("FAIL %s result: got %h required %h", name, result, m_res); end
    total++;
    if (pc_target !== m_tgt) begin bad++; $display("FAIL %s pc_target: got %h required %h", name, pc_target, m_tgt); end
  endtask

  task automatic test_reset();
    reset = 1;
    drive(ALU, 0, 32'h1234, 32'h1, 0, 5'd3, 3'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall, wb_en, pc_load} !== 3'b000) begin bad++; $display("FAIL reset flags: got %b required 000", {stall, wb_en, pc_load}); end
    total++;
    if (wb_addr !== 5'd0) begin bad++; $display("FAIL reset wb_addr: got %0d required 0", wb_addr); end
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL reset result: got %h required 0", result); end
    total++;
    if (pc_target !== 32'd0) begin bad++; $display("FAIL reset pc_target: got %h required 0", pc_target); end
    m_res = 0; m_tgt = 0; m_addr = 0;
    clear_flags();
    reset = 0;
  endtask

  task automatic test_alu();
    drive(ALU | RT, 0, 32'hFFFF_FFFF, 32'h1, 0, 5'd5, 3'd0, 0);
    run_op("add");
    total++;
    if (result !== 32'h0 || wb_en !== 1'b1 || wb_addr !== 5'd5) begin bad++; $display("FAIL add_const: result=%h wb_en=%b wb_addr=%0d required 0/1/5", result, wb_en, wb_addr); end
    drive(ALU | RT, 0, 32'd3, 32'd5, 0, 5'd6, 3'd0, 1);
    run_op("sub");
    total++;
    if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_const: got %h required fffffffe", result); end
    drive(ALU, 0, 32'd3, 32'd5, 0, 5'd6, 3'd0, 1);
    run_op("addi_func7");
    drive(ALU | RT, 0, 32'hFFFF_FFFF, 32'd1, 0, 5'd7, 3'd2, 1);
    run_op("slt");
    total++;
    if (result !== 32'd1) begin bad++; $display("FAIL slt_const: got %h required 1", result); end
    drive(ALU | RT, 0, 32'hFFFF_FFFF, 32'd1, 0, 5'd7, 3'd3, 1);
    run_op("sltu");
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL sltu_const: got %h required 0", result); end
    drive(ALU, 0, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 5'd0, 3'd4, 0);
    run_op("xor_x0");
  endtask

  task automatic test_shift();
    drive(ALU | RT, 0, 32'h8000_0000, 32'd4, 0, 5'd9, 3'd5, 1);
    run_op("sra4");
    total++;
    if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra_const: got %h required f8000000", result); end
    drive(ALU, 0, 32'h8000_0000, 32'h24, 0, 5'd9, 3'd5, 0);
    run_op("srl_upper_ignored");
    drive(ALU | RT, 0, 32'hDEAD_BEEF, 32'h20, 0, 5'd10, 3'd1, 0);
    run_op("sll_shamt0");
    total++;
    if (result !== 32'hDEAD_BEEF) begin bad++; $display("FAIL shamt0_const: got %h required deadbeef", result); end
    drive(ALU, 0, 32'h0000_0001, 32'd31, 0, 5'd11, 3'd1, 0);
    run_op("sll31");
  endtask

  task automatic test_branch_jump();
    drive(BR, 32'h100, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFF0, 5'd4, 3'd4, 0);
    run_op("blt");
    total++;
    if (pc_load !== 1'b1 || pc_target !== 32'hF0 || wb_en !== 1'b0) begin bad++; $display("FAIL blt_const: pc_load=%b pc_target=%h wb_en=%b required 1/f0/0", pc_load, pc_target, wb_en); end
    drive(BR, 32'h100, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFF0, 5'd4, 3'd7, 0);
    run_op("bgeu");
    drive(BR, 32'h100, 32'd5, 32'd5, 32'h40, 5'd4, 3'd2, 0);
    run_op("br010");
    drive(JP | RG, 32'h40, 32'h203, 32'h10, 0, 5'd1, 3'd0, 0);
    run_op("jalr");
    total++;
    if (pc_target !== 32'h212 || result !== 32'h44 || wb_en !== 1'b1) begin bad++; $display("FAIL jalr_const: pc_target=%h result=%h wb_en=%b required 212/44/1", pc_target, result, wb_en); end
    drive(JP, 32'h40, 32'h80, 0, 0, 5'd0, 3'd0, 0);
    run_op("jal_x0");
    drive(UI, 32'h1000, 32'hABCD_E000, 0, 0, 5'd2, 3'd0, 0);
    run_op("lui");
    drive(UI | AP, 32'h1000, 32'hABCD_E000, 0, 0, 5'd2, 3'd0, 0);
    run_op("auipc");
    drive(ALU | BR | JP | UI, 32'h200, 32'h8, 32'h8, 32'h4, 5'd3, 3'd1, 0);
    run_op("priority_jump");
    drive(ALU | BR | UI, 32'h200, 32'h8, 32'h8, 32'h4, 5'd3, 3'd0, 0);
    run_op("priority_branch");
  endtask

  task automatic test_back_to_back();
    drive(ALU, 0, 32'd10, 32'd20, 0, 5'd8, 3'd0, 0);
    run_op("b2b_0");
    drive(ALU, 0, 32'hFF, 32'h0F, 0, 5'd9, 3'd7, 0);
    run_op("b2b_1");
    @(posedge clk); #1;
    total++;
    if (wb_en !== 1'b0 || pc_load !== 1'b0) begin bad++; $display("FAIL idle_pulse: wb_en=%b pc_load=%b required 0/0", wb_en, pc_load); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      {is_alu, is_rtype, is_branch, is_jump, is_reg, is_ui, add_pc} = 7'($urandom);
      if (!(is_alu || is_branch || is_jump || is_ui)) is_alu = 1;
      pc = $urandom & 32'hFFFF_FFFC;
      operand_a = ($urandom_range(0, 3) == 0) ? operand_b : $urandom;
      operand_b = $urandom;
      branch_dest = $urandom;
      dest = 5'($urandom);
      func3 = 3'($urandom);
      func7 = 1'($urandom);
      run_op($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid_shift();
    drive(ALU | RT, 0, 32'h8000_0000, 32'd6, 0, 5'd12, 3'd5, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    total++;
    if (stall !== 1'b0 || wb_en !== 1'b0 || result !== 32'd0) begin bad++; $display("FAIL mid_shift_reset: stall=%b wb_en=%b result=%h required 0/0/0", stall, wb_en, result); end
    reset = 0;
    m_res = 0; m_tgt = 0; m_addr = 0;
    drive(ALU, 0, 32'd7, 32'd8, 0, 5'd13, 3'd0, 0);
    run_op("after_reset");
  endtask

  initial begin
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu();
    test_shift();
    test_branch_jump();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
